// File: rtl/sdram_ctrl_cmd_pkg.sv
// Shared definitions for the SDRAM command controller: pin command codes,
// FSM state encoding and mode-register field positions.
package sdram_ctrl_cmd_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_REFRESH,
    ST_ACTIVE,
    ST_RW,
    ST_CAS_WAIT,
    ST_RECOVER
  } state_e;

  localparam int         MR_BL_LSB = 0;
  localparam int         MR_BT_BIT = 3;
  localparam int         MR_CL_LSB = 4;
  localparam logic [2:0] MR_BL_1   = 3'b000;
  localparam logic       MR_BT_SEQ = 1'b0;

  // Address bit that selects all-bank precharge / auto-precharge.
  localparam int AP_BIT = 10;

  function automatic logic [12:0] mode_word(input int cas_lat);
    logic [12:0] mw;
    mw = '0;
    mw[MR_BL_LSB +: 3] = MR_BL_1;
    mw[MR_BT_BIT]      = MR_BT_SEQ;
    mw[MR_CL_LSB +: 3] = 3'(cas_lat);
    return mw;
  endfunction

  function automatic logic is_init_state(input state_e s);
    return s inside {ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF1, ST_INIT_REF2, ST_INIT_MRS};
  endfunction

endpackage

// File: rtl/sdram_ctrl_cmd_reftimer.sv
// Refresh interval timer with a sticky pending flag; an expiry while a
// request is already pending is absorbed.
module sdram_ctrl_reftimer #(
  parameter int INTERVAL = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic pending
);

  localparam int            RW   = $clog2(INTERVAL + 1);
  localparam logic [RW-1:0] LAST = RW'(INTERVAL - 1);

  logic [RW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          expire;

  always_comb begin
    expire    = enable && (cnt_q == LAST);
    cnt_d     = cnt_q;
    if (enable) cnt_d = expire ? '0 : cnt_q + 1'b1;
    // A fresh expiry outranks a clear so a back-to-back request is not lost.
    pending_d = expire | (pending_q & ~clear);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Expiry is visible the same cycle so IDLE can give refresh priority over acc.
  assign pending = pending_q | expire;

endmodule

// File: rtl/sdram_ctrl_cmd.sv
// SDRAM command sequencer: power-up init, periodic refresh and single-beat
// read/write accesses with auto-precharge. All sd_* pins are registered.
module sdram_ctrl_cmd
  import sdram_ctrl_cmd_pkg::*;
#(
  parameter int CAS_LAT      = 2,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int T_WR         = 2,
  parameter int REF_INTERVAL = 780,
  parameter int INIT_CYCLES  = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc,
  input  logic        we,
  input  logic [1:0]  ba,
  input  logic [12:0] row_addr,
  input  logic [8:0]  col_addr,
  input  logic [31:0] data,
  input  logic [3:0]  mask,
  output logic        finish,
  output logic        busy,
  output logic        ref_o,
  output logic [31:0] rd_data,
  output logic        sd_cke,
  output logic [3:0]  sd_cmd,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_addr,
  output logic [3:0]  sd_dqm,
  output logic [31:0] sd_dq_o,
  output logic        sd_dq_oe,
  input  logic [31:0] sd_dq_i
);

  // Handshake: acc is sampled only while busy=0 (IDLE); once ACT is issued the
  // access runs to completion regardless of acc and ends with a one-cycle finish.

  localparam int            CW       = 16;
  localparam logic [CW-1:0] INIT_END = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] RP_END   = CW'(T_RP - 1);
  localparam logic [CW-1:0] RFC_END  = CW'(T_RFC - 1);
  localparam logic [CW-1:0] RCD_END  = CW'(T_RCD - 1);
  localparam logic [CW-1:0] CL_END   = CW'(CAS_LAT - 1);
  localparam logic [CW-1:0] MRS_END  = CW'(1);
  localparam logic [CW-1:0] WREC_END = CW'(T_WR + T_RP - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        we_q, we_d;
  logic [1:0]  ba_q, ba_d;
  logic [8:0]  col_q, col_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;

  logic        sd_cke_q, sd_cke_d;
  logic [3:0]  sd_cmd_q, sd_cmd_d;
  logic [1:0]  sd_ba_q, sd_ba_d;
  logic [12:0] sd_addr_q, sd_addr_d;
  logic [3:0]  sd_dqm_q, sd_dqm_d;
  logic [31:0] sd_dq_o_q, sd_dq_o_d;
  logic        sd_dq_oe_q, sd_dq_oe_d;
  logic        finish_q, finish_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic ref_pending;
  logic ref_clear;

  sdram_ctrl_reftimer #(
    .INTERVAL(REF_INTERVAL)
  ) u_reftimer (
    .clk    (clk),
    .rst    (rst),
    .enable (!is_init_state(state_q)),
    .clear  (ref_clear),
    .pending(ref_pending)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    we_d       = we_q;
    ba_d       = ba_q;
    col_d      = col_q;
    data_d     = data_q;
    mask_d     = mask_q;
    sd_cke_d   = 1'b1;
    sd_cmd_d   = CMD_NOP;
    sd_ba_d    = sd_ba_q;
    sd_addr_d  = sd_addr_q;
    sd_dqm_d   = 4'hF;
    sd_dq_o_d  = sd_dq_o_q;
    sd_dq_oe_d = 1'b0;
    finish_d   = 1'b0;
    rd_data_d  = rd_data_q;
    ref_clear  = 1'b0;

    case (state_q)
      ST_INIT_WAIT: begin
        if (cnt_q == INIT_END) begin
          sd_cmd_d          = CMD_PRE;
          sd_addr_d         = '0;
          sd_addr_d[AP_BIT] = 1'b1;
          cnt_d             = '0;
          state_d           = ST_INIT_PRE;
        end
      end
      ST_INIT_PRE: begin
        if (cnt_q == RP_END) begin
          sd_cmd_d = CMD_REF;
          cnt_d    = '0;
          state_d  = ST_INIT_REF1;
        end
      end
      ST_INIT_REF1: begin
        if (cnt_q == RFC_END) begin
          sd_cmd_d = CMD_REF;
          cnt_d    = '0;
          state_d  = ST_INIT_REF2;
        end
      end
      ST_INIT_REF2: begin
        if (cnt_q == RFC_END) begin
          sd_cmd_d  = CMD_MRS;
          sd_ba_d   = 2'b00;
          sd_addr_d = mode_word(CAS_LAT);
          cnt_d     = '0;
          state_d   = ST_INIT_MRS;
        end
      end
      ST_INIT_MRS: begin
        if (cnt_q == MRS_END) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (ref_pending) begin
          sd_cmd_d = CMD_REF;
          state_d  = ST_REFRESH;
        end else if (acc) begin
          we_d      = we;
          ba_d      = ba;
          col_d     = col_addr;
          data_d    = data;
          mask_d    = mask;
          sd_cmd_d  = CMD_ACT;
          sd_ba_d   = ba;
          sd_addr_d = row_addr;
          state_d   = ST_ACTIVE;
        end
      end
      ST_REFRESH: begin
        if (cnt_q == RFC_END) begin
          ref_clear = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == RCD_END) begin
          sd_cmd_d          = we_q ? CMD_WR : CMD_RD;
          sd_ba_d           = ba_q;
          sd_addr_d         = '0;
          sd_addr_d[AP_BIT] = 1'b1;
          sd_addr_d[8:0]    = col_q;
          sd_dqm_d          = mask_q;
          if (we_q) begin
            sd_dq_o_d  = data_q;
            sd_dq_oe_d = 1'b1;
          end
          state_d = ST_RW;
        end
      end
      ST_RW: begin
        cnt_d = '0;
        if (we_q) begin
          finish_d = 1'b1;
          state_d  = ST_RECOVER;
        end else begin
          state_d = ST_CAS_WAIT;
        end
      end
      ST_CAS_WAIT: begin
        if (cnt_q == CL_END) begin
          rd_data_d = sd_dq_i;
          finish_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        // Writes also cover write recovery before the auto-precharge starts.
        if (cnt_q == (we_q ? WREC_END : RP_END)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_INIT_WAIT;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      ba_q       <= 2'b00;
      col_q      <= '0;
      data_q     <= '0;
      mask_q     <= 4'h0;
      sd_cke_q   <= 1'b0;
      sd_cmd_q   <= CMD_NOP;
      sd_ba_q    <= 2'b00;
      sd_addr_q  <= '0;
      sd_dqm_q   <= 4'hF;
      sd_dq_o_q  <= '0;
      sd_dq_oe_q <= 1'b0;
      finish_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      ba_q       <= ba_d;
      col_q      <= col_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      sd_cke_q   <= sd_cke_d;
      sd_cmd_q   <= sd_cmd_d;
      sd_ba_q    <= sd_ba_d;
      sd_addr_q  <= sd_addr_d;
      sd_dqm_q   <= sd_dqm_d;
      sd_dq_o_q  <= sd_dq_o_d;
      sd_dq_oe_q <= sd_dq_oe_d;
      finish_q   <= finish_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign ref_o    = ref_pending;
  assign finish   = finish_q;
  assign rd_data  = rd_data_q;
  assign sd_cke   = sd_cke_q;
  assign sd_cmd   = sd_cmd_q;
  assign sd_ba    = sd_ba_q;
  assign sd_addr  = sd_addr_q;
  assign sd_dqm   = sd_dqm_q;
  assign sd_dq_o  = sd_dq_o_q;
  assign sd_dq_oe = sd_dq_oe_q;

endmodule

// File: tb/tb_sdram_ctrl_cmd.sv
// Directed cycle-by-cycle bench for sdram_ctrl_cmd with a small SDRAM read model.
module tb_sdram_ctrl_cmd;

  localparam int         CL   = 2;
  localparam int         NCYC = 133;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] RD   = 4'b0101;
  localparam logic [3:0] WR   = 4'b0100;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] REF  = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc, we;
  logic [1:0]  ba;
  logic [12:0] row_addr;
  logic [8:0]  col_addr;
  logic [31:0] data;
  logic [3:0]  mask;
  logic        finish, busy, ref_o;
  logic [31:0] rd_data;
  logic        sd_cke;
  logic [3:0]  sd_cmd;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [3:0]  sd_dqm;
  logic [31:0] sd_dq_o;
  logic        sd_dq_oe;
  logic [31:0] sd_dq_i;

  sdram_ctrl_cmd #(
    .CAS_LAT     (CL),
    .REF_INTERVAL(60),
    .INIT_CYCLES (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .acc     (acc),
    .we      (we),
    .ba      (ba),
    .row_addr(row_addr),
    .col_addr(col_addr),
    .data    (data),
    .mask    (mask),
    .finish  (finish),
    .busy    (busy),
    .ref_o   (ref_o),
    .rd_data (rd_data),
    .sd_cke  (sd_cke),
    .sd_cmd  (sd_cmd),
    .sd_ba   (sd_ba),
    .sd_addr (sd_addr),
    .sd_dqm  (sd_dqm),
    .sd_dq_o (sd_dq_o),
    .sd_dq_oe(sd_dq_oe),
    .sd_dq_i (sd_dq_i)
  );

  always #5 clk = ~clk;

  // SDRAM model: single word store, read data valid CL cycles after RD on the pins.
  logic [31:0] mem_word = 32'h0;
  logic [CL:0] rd_sr    = '0;
  always @(negedge clk) begin
    rd_sr <= {rd_sr[CL-1:0], (sd_cmd == RD)};
    if (sd_cmd == WR && sd_dq_oe && sd_dqm == 4'h0) mem_word <= sd_dq_o;
  end
  assign sd_dq_i = rd_sr[CL] ? mem_word : 32'h0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [3:0]  exp_cmd    [NCYC];
  logic [3:0]  exp_dqm    [NCYC];
  logic        exp_oe     [NCYC];
  logic        exp_finish [NCYC];
  logic        exp_busy   [NCYC];
  logic        exp_ref    [NCYC];
  logic        exp_cke    [NCYC];
  logic [31:0] exp_rdata  [NCYC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      exp_cmd[c]    = NOP;
      exp_dqm[c]    = 4'hF;
      exp_oe[c]     = 1'b0;
      exp_finish[c] = 1'b0;
      exp_busy[c]   = !(c == 29 || c == 37 || c == 45 || (c >= 53 && c <= 88) || c == 96 || c >= 131);
      exp_ref[c]    = (c >= 88 && c <= 95);
      exp_cke[c]    = !(c == 0 || c == 101 || c == 102);
      exp_rdata[c]  = (c >= 43 && c <= 100) ? 32'hDEADBEEF : 32'h0;
    end
    exp_cmd[11]  = PRE; exp_cmd[13]  = REF; exp_cmd[20]  = REF; exp_cmd[27]  = MRS;
    exp_cmd[30]  = ACT; exp_cmd[32]  = WR;  exp_cmd[38]  = ACT; exp_cmd[40]  = RD;
    exp_cmd[46]  = ACT; exp_cmd[48]  = WR;  exp_cmd[89]  = REF; exp_cmd[97]  = ACT;
    exp_cmd[99]  = RD;  exp_cmd[113] = PRE; exp_cmd[115] = REF; exp_cmd[122] = REF;
    exp_cmd[129] = MRS;
    exp_dqm[32] = 4'h0; exp_dqm[40] = 4'h0; exp_dqm[48] = 4'b1010; exp_dqm[99] = 4'h0;
    exp_oe[32] = 1'b1; exp_oe[48] = 1'b1;
    exp_finish[33] = 1'b1; exp_finish[43] = 1'b1; exp_finish[49] = 1'b1;

    rst = 1'b0; acc = 1'b0; we = 1'b0; ba = 2'b00;
    row_addr = '0; col_addr = '0; data = '0; mask = 4'h0;
    repeat (3) @(posedge clk);
    #1;

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      rst = !(c == 100 || c == 101);
      acc = 1'b0;
      case (c)
        29: begin
          acc = 1'b1; we = 1'b1; ba = 2'd1; row_addr = 13'h1A5; col_addr = 9'h0F3;
          data = 32'hDEADBEEF; mask = 4'h0;
        end
        37: begin
          acc = 1'b1; we = 1'b0; ba = 2'd1; row_addr = 13'h1A5; col_addr = 9'h0F3;
          data = 32'h0BAD0BAD; mask = 4'h0;
        end
        45: begin
          acc = 1'b1; we = 1'b1; ba = 2'd2; row_addr = 13'h0C3; col_addr = 9'h1FF;
          data = 32'h12345678; mask = 4'b1010;
        end
        default: begin
          if (c >= 88 && c <= 96) begin
            acc = 1'b1; we = 1'b0; ba = 2'd3; row_addr = 13'h1FFF; col_addr = 9'h000;
            data = 32'h0; mask = 4'h0;
          end
        end
      endcase

      @(negedge clk);
      check("sd_cmd",   32'(sd_cmd),   32'(exp_cmd[c]));
      check("sd_dqm",   32'(sd_dqm),   32'(exp_dqm[c]));
      check("sd_dq_oe", 32'(sd_dq_oe), 32'(exp_oe[c]));
      check("finish",   32'(finish),   32'(exp_finish[c]));
      check("busy",     32'(busy),     32'(exp_busy[c]));
      check("ref",      32'(ref_o),    32'(exp_ref[c]));
      check("sd_cke",   32'(sd_cke),   32'(exp_cke[c]));
      check("rd_data",  rd_data,       exp_rdata[c]);

      case (c)
        11:  check("pre_all_a10", 32'(sd_addr[10]), 32'd1);
        27:  begin
          check("mrs_addr", 32'(sd_addr), 32'h020);
          check("mrs_ba",   32'(sd_ba),   32'd0);
        end
        30:  begin
          check("act1_ba",   32'(sd_ba),   32'd1);
          check("act1_addr", 32'(sd_addr), 32'h1A5);
        end
        32:  begin
          check("wr1_ba",   32'(sd_ba),   32'd1);
          check("wr1_addr", 32'(sd_addr), 32'h4F3);
          check("wr1_dq",   sd_dq_o,      32'hDEADBEEF);
        end
        40:  check("rd_addr", 32'(sd_addr), 32'h4F3);
        46:  begin
          check("act3_ba",   32'(sd_ba),   32'd2);
          check("act3_addr", 32'(sd_addr), 32'h0C3);
        end
        48:  begin
          check("wr3_ba",   32'(sd_ba),   32'd2);
          check("wr3_addr", 32'(sd_addr), 32'h5FF);
          check("wr3_dq",   sd_dq_o,      32'h12345678);
        end
        97:  begin
          check("act4_ba",   32'(sd_ba),   32'd3);
          check("act4_addr", 32'(sd_addr), 32'h1FFF);
        end
        99:  check("rd4_addr", 32'(sd_addr), 32'h400);
        101: begin
          check("rst_ba",   32'(sd_ba),   32'd0);
          check("rst_addr", 32'(sd_addr), 32'd0);
          check("rst_dq_o", sd_dq_o,      32'd0);
        end
        default: ;
      endcase

      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
